// File: rtl/probe_capture_mux.sv
// probe_capture_mux: selects one of NUM_CH probe buses for live observation and
// captures DEPTH qualified samples after a masked trigger for later readout.
//   inClock/inReset         clock, async active-high reset
//   inProbeData             NUM_CH packed channels of CH_WIDTH bits
//   inSel/inSelLoad         channel select and its load strobe
//   inSampleEn              sample qualifier
//   inArm                   arm, or abort and re-arm
//   inTrigMask/inTrigValue  trigger compare
//   inReadEnable            pop one captured sample
//   outLive                 registered selected channel
//   outData/outValid        readout data and its one-cycle strobe
//   outState/outCount       FSM state and sample count
module probe_capture_mux #(
  parameter int NUM_CH   = 8,
  parameter int CH_WIDTH = 4,
  parameter int DEPTH    = 16,
  localparam int SEL_W   = $clog2(NUM_CH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       inClock,
  input  logic                       inReset,
  input  logic [NUM_CH*CH_WIDTH-1:0] inProbeData,
  input  logic [SEL_W-1:0]           inSel,
  input  logic                       inSelLoad,
  input  logic                       inSampleEn,
  input  logic                       inArm,
  input  logic [CH_WIDTH-1:0]        inTrigMask,
  input  logic [CH_WIDTH-1:0]        inTrigValue,
  input  logic                       inReadEnable,
  output logic [CH_WIDTH-1:0]        outLive,
  output logic [CH_WIDTH-1:0]        outData,
  output logic                       outValid,
  output logic [1:0]                 outState,
  output logic [CNT_W-1:0]           outCount
);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CH_WIDTH-1:0] live_q, data_q, data_d;
  logic valid_q, valid_d, we;
  logic [CH_WIDTH-1:0] mem_q [DEPTH];
  logic [CH_WIDTH-1:0] ch [NUM_CH];
  logic [CH_WIDTH-1:0] chan;
  logic match;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch[k] = inProbeData[k*CH_WIDTH +: CH_WIDTH];
  end
  assign chan  = ch[sel_q];
  assign match = ((chan ^ inTrigValue) & inTrigMask) == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    data_d  = data_q;
    valid_d = 1'b0;
    we      = 1'b0;
    sel_d   = (inSelLoad && (state_q == IDLE || state_q == DONE)
               && {1'b0, inSel} < (SEL_W+1)'(NUM_CH)) ? inSel : sel_q;
    if (inArm) begin
      state_d = ARMED;
      cnt_d   = '0;
      rd_d    = '0;
    end else begin
      case (state_q)
        ARMED: if (inSampleEn && match) begin
          we      = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = DEPTH == 1 ? DONE : CAPT;
        end
        CAPT: if (inSampleEn) begin
          we      = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = cnt_d == CNT_W'(DEPTH) ? DONE : CAPT;
        end
        DONE: if (inReadEnable && cnt_q != '0) begin
          data_d  = mem_q[rd_q];
          valid_d = 1'b1;
          rd_d    = rd_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = cnt_q == CNT_W'(1) ? IDLE : DONE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      live_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      live_q  <= chan;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  // The sample count doubles as the write pointer while acquiring.
  always_ff @(posedge inClock) begin
    if (we) mem_q[cnt_q[PTR_W-1:0]] <= chan;
  end
  assign outLive  = live_q;
  assign outData  = data_q;
  assign outValid = valid_q;
  assign outState = state_q;
  assign outCount = cnt_q;
endmodule

// File: tb/tb_probe_capture_mux.sv
// tb_probe_capture_mux: directed self-checking bench for probe_capture_mux.
module tb_probe_capture_mux;
  logic        inClock = 0, inReset = 1;
  logic [31:0] inProbeData;
  logic [2:0]  inSel = 0;
  logic        inSelLoad = 0, inSampleEn = 0, inArm = 0, inReadEnable = 0;
  logic [3:0]  inTrigMask = 0, inTrigValue = 0;
  logic [3:0]  outLive, outData;
  logic        outValid;
  logic [1:0]  outState;
  logic [2:0]  outCount;
  logic [3:0]  ch [8];
  int checks = 0, errors = 0;

  probe_capture_mux #(.NUM_CH(8), .CH_WIDTH(4), .DEPTH(4)) dut (
    .inClock(inClock), .inReset(inReset), .inProbeData(inProbeData),
    .inSel(inSel), .inSelLoad(inSelLoad), .inSampleEn(inSampleEn),
    .inArm(inArm), .inTrigMask(inTrigMask), .inTrigValue(inTrigValue),
    .inReadEnable(inReadEnable), .outLive(outLive), .outData(outData),
    .outValid(outValid), .outState(outState), .outCount(outCount)
  );

  always #5 inClock = ~inClock;
  always_comb for (int i = 0; i < 8; i++) inProbeData[i*4 +: 4] = ch[i];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge inClock);
    #1;
  endtask

  task automatic samp(input logic [3:0] v);
    ch[2] = v;
    inSampleEn = 1;
    step();
    inSampleEn = 0;
  endtask

  task automatic rd(input string tag, input logic [3:0] d, input logic [2:0] c, input logic [1:0] s);
    inReadEnable = 1;
    step();
    chk({tag, "_data"}, outData, d);
    chk({tag, "_valid"}, outValid, 1);
    chk({tag, "_cnt"}, outCount, c);
    chk({tag, "_state"}, outState, s);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ch[i] = 0;
    #12;
    chk("rst_live", outLive, 0);
    chk("rst_data", outData, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_state", outState, 0);
    chk("rst_cnt", outCount, 0);
    @(negedge inClock);
    inReset = 0;
    step();
    // Live select: old channel after load edge, new one after the next
    ch[5] = 4'hA;
    inSel = 5;
    inSelLoad = 1;
    step();
    inSelLoad = 0;
    chk("live_old", outLive, 0);
    step();
    chk("live_new", outLive, 4'hA);
    // Triggered capture on channel 2
    inSel = 2;
    inSelLoad = 1;
    step();
    inSelLoad = 0;
    inTrigMask = 4'hF;
    inTrigValue = 4'h3;
    ch[2] = 4'h3;
    inSampleEn = 1;
    inArm = 1;
    step();
    inArm = 0;
    inSampleEn = 0;
    chk("arm_state", outState, 1);
    chk("arm_cnt", outCount, 0);
    samp(1);
    samp(2);
    chk("pretrig_state", outState, 1);
    samp(3);
    chk("trig_state", outState, 2);
    chk("trig_cnt", outCount, 1);
    samp(4);
    samp(5);
    chk("cap_cnt", outCount, 3);
    samp(6);
    chk("done_state", outState, 3);
    chk("done_cnt", outCount, 4);
    samp(7);
    chk("done_hold_cnt", outCount, 4);
    // Back-to-back readout
    rd("rd0", 3, 3, 3);
    rd("rd1", 4, 2, 3);
    rd("rd2", 5, 1, 3);
    rd("rd3", 6, 0, 0);
    step();
    inReadEnable = 0;
    chk("rd_idle_valid", outValid, 0);
    chk("rd_idle_data", outData, 6);
    chk("rd_idle_state", outState, 0);
    // Sparse qualifier
    inArm = 1;
    step();
    inArm = 0;
    samp(3);
    chk("sp_trig_cnt", outCount, 1);
    for (int v = 4'hA; v <= 4'hC; v++) begin
      ch[2] = 4'h9;
      step();
      step();
      chk("sp_idle_cnt", outCount, v - 4'hA + 1);
      samp(v[3:0]);
      chk("sp_cnt", outCount, v - 4'hA + 2);
    end
    chk("sp_done", outState, 3);
    rd("sp0", 3, 3, 3);
    rd("sp1", 4'hA, 2, 3);
    rd("sp2", 4'hB, 1, 3);
    rd("sp3", 4'hC, 0, 0);
    inReadEnable = 0;
    step();
    // Abort during capture, with a matching qualified sample in the arm cycle
    inArm = 1;
    step();
    inArm = 0;
    samp(3);
    samp(4);
    chk("ab_pre_cnt", outCount, 2);
    ch[2] = 3;
    inSampleEn = 1;
    inArm = 1;
    step();
    inArm = 0;
    inSampleEn = 0;
    chk("ab_state", outState, 1);
    chk("ab_cnt", outCount, 0);
    samp(4);
    chk("ab_nomatch", outState, 1);
    samp(3);
    samp(5);
    samp(6);
    samp(7);
    chk("ab_done", outState, 3);
    // Arm beats read in DONE
    inArm = 1;
    inReadEnable = 1;
    step();
    inArm = 0;
    inReadEnable = 0;
    chk("armrd_valid", outValid, 0);
    chk("armrd_state", outState, 1);
    chk("armrd_cnt", outCount, 0);
    // Select load ignored while ARMED
    ch[2] = 4'h1;
    ch[6] = 4'hE;
    inSel = 6;
    inSelLoad = 1;
    step();
    inSelLoad = 0;
    step();
    chk("sel_frozen", outLive, 4'h1);
    samp(3);
    samp(8);
    chk("prerst_state", outState, 2);
    // Asynchronous reset between edges
    ch[0] = 4'h5;
    #3;
    inReset = 1;
    #1;
    chk("arst_state", outState, 0);
    chk("arst_cnt", outCount, 0);
    chk("arst_live", outLive, 0);
    chk("arst_data", outData, 0);
    chk("arst_valid", outValid, 0);
    @(negedge inClock);
    inReset = 0;
    step();
    chk("arst_sel0", outLive, 4'h5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
